// File: rtl/rx_dp_lanes_if.sv
// Bus bundle for rx_dp_lanes: valid/data/control toward the data path, registered results back.
// ComCount is present only when RXDP_COMCOUNT_EN is defined.
interface rx_dp_lanes_if #(
  parameter int unsigned LANES = 1
);
  logic                 InValid;
  logic [8*LANES-1:0]   InData;
  logic [LANES-1:0]     InCtrl;
  logic                 ScrambleEn;
  logic                 OutValid;
  logic [8*LANES-1:0]   OutByteRaw;
  logic [8*LANES-1:0]   OutByteSc;
  logic [LANES-1:0]     OutCtrl;
`ifdef RXDP_COMCOUNT_EN
  logic [15:0]          ComCount;
`endif

  modport master (
    output InValid, InData, InCtrl, ScrambleEn,
    input  OutValid, OutByteRaw, OutByteSc, OutCtrl
`ifdef RXDP_COMCOUNT_EN
    , input ComCount
`endif
  );

  modport slave (
    input  InValid, InData, InCtrl, ScrambleEn,
    output OutValid, OutByteRaw, OutByteSc, OutCtrl
`ifdef RXDP_COMCOUNT_EN
    , output ComCount
`endif
  );
endinterface

// File: rtl/rx_dp_lanes.sv
// Multi-lane Rx data path: per-lane 16-bit descrambler LFSR with COM reseed / SKP freeze.
// Define RXDP_COMCOUNT_EN to add the saturating ComCount COM-symbol counter.
module rx_dp_lanes #(
  parameter int unsigned LANES = 1,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input logic          ClkPci,
  input logic          Reset,
  rx_dp_lanes_if.slave dp
);
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;

  logic [LANES-1:0][15:0] lfsr;
  logic [LANES-1:0][15:0] lfsrNext;
  logic [8*LANES-1:0]     scNext;
  logic                   outValid;
  logic [8*LANES-1:0]     outRaw;
  logic [8*LANES-1:0]     outSc;
  logic [LANES-1:0]       outCtrl;

  // Returns {LFSR after 8 steps, scrambler byte}; bit i of the byte is L[15] before step i.
  function automatic logic [23:0] lfsrStep8(input logic [15:0] lIn);
    logic [15:0] l;
    logic [7:0]  s;
    l = lIn;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i] = l[15];
      l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {l, s};
  endfunction

  always_comb begin
    logic [23:0] adv;
    logic [7:0]  sym;
    lfsrNext = lfsr;
    scNext   = dp.InData;
    for (int unsigned n = 0; n < LANES; n++) begin
      sym = dp.InData[8*n +: 8];
      adv = lfsrStep8(lfsr[n]);
      if (dp.InCtrl[n]) begin
        if (sym == K_COM)
          lfsrNext[n] = SEED;
        else if (sym != K_SKP)
          lfsrNext[n] = adv[23:8];
      end else begin
        scNext[8*n +: 8] = sym ^ (adv[7:0] & {8{dp.ScrambleEn}});
        lfsrNext[n]      = adv[23:8];
      end
    end
  end

  always_ff @(posedge ClkPci or posedge Reset) begin
    if (Reset) begin
      outValid <= 1'b0;
      outRaw   <= '0;
      outSc    <= '0;
      outCtrl  <= '0;
      for (int unsigned n = 0; n < LANES; n++)
        lfsr[n] <= SEED;
    end else begin
      outValid <= dp.InValid;
      if (dp.InValid) begin
        outRaw  <= dp.InData;
        outSc   <= scNext;
        outCtrl <= dp.InCtrl;
        lfsr    <= lfsrNext;
      end
    end
  end

  assign dp.OutValid   = outValid;
  assign dp.OutByteRaw = outRaw;
  assign dp.OutByteSc  = outSc;
  assign dp.OutCtrl    = outCtrl;

`ifdef RXDP_COMCOUNT_EN
  logic [15:0] comCount;
  logic [15:0] comCountNext;

  always_comb begin
    logic [4:0]  comNum;
    logic [16:0] comSum;
    comNum = '0;
    for (int unsigned n = 0; n < LANES; n++)
      if (dp.InCtrl[n] && dp.InData[8*n +: 8] == K_COM)
        comNum = comNum + 5'd1;
    comSum       = {1'b0, comCount} + {12'd0, comNum};
    comCountNext = comSum[16] ? 16'hFFFF : comSum[15:0];
  end

  always_ff @(posedge ClkPci or posedge Reset) begin
    if (Reset)
      comCount <= '0;
    else if (dp.InValid)
      comCount <= comCountNext;
  end

  assign dp.ComCount = comCount;
`endif
endmodule

// File: tb/tb_rx_dp_lanes.sv
// Directed bench for rx_dp_lanes (4 lanes) with hand-computed scrambler bytes.
// Scrambler bytes from SEED FFFF: FF, 17, C0, 14.
module tb_rx_dp_lanes;
  logic ClkPci;
  logic Reset;
  int   checkCnt = 0;
  int   errCnt   = 0;

  rx_dp_lanes_if #(.LANES(4)) bus ();

  rx_dp_lanes #(.LANES(4), .SEED(16'hFFFF)) dut (
    .ClkPci (ClkPci),
    .Reset  (Reset),
    .dp     (bus)
  );

  initial begin
    ClkPci = 1'b0;
    forever #5 ClkPci = ~ClkPci;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one input vector, clock it, and leave time just past the edge for sampling.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k);
    bus.InValid = v;
    bus.InData  = d;
    bus.InCtrl  = k;
    @(posedge ClkPci);
    #1;
  endtask

  initial begin
    Reset          = 1'b1;
    bus.InValid    = 1'b0;
    bus.InData     = '0;
    bus.InCtrl     = '0;
    bus.ScrambleEn = 1'b1;
    @(posedge ClkPci);
    #1;
    checkVal("rst_valid", {31'd0, bus.OutValid}, 32'd0);
    checkVal("rst_raw",   bus.OutByteRaw, 32'd0);
    checkVal("rst_sc",    bus.OutByteSc,  32'd0);
    checkVal("rst_ctrl",  {28'd0, bus.OutCtrl}, 32'd0);
`ifdef RXDP_COMCOUNT_EN
    checkVal("rst_comcnt", {16'd0, bus.ComCount}, 32'd0);
`endif
    Reset = 1'b0;

    // Basic scrambled stream: COM then D00 x3 on every lane.
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    checkVal("a_com_sc",    bus.OutByteSc, 32'hBCBCBCBC);
    checkVal("a_com_valid", {31'd0, bus.OutValid}, 32'd1);
    checkVal("a_com_ctrl",  {28'd0, bus.OutCtrl}, 32'hF);
    step(1'b1, 32'h0, 4'h0);
    checkVal("a_d1_sc",   bus.OutByteSc, 32'hFFFFFFFF);
    checkVal("a_d1_ctrl", {28'd0, bus.OutCtrl}, 32'h0);
    step(1'b1, 32'h0, 4'h0);
    checkVal("a_d2_sc", bus.OutByteSc, 32'h17171717);
    step(1'b1, 32'h0, 4'h0);
    checkVal("a_d3_sc",  bus.OutByteSc, 32'hC0C0C0C0);
    checkVal("a_d3_raw", bus.OutByteRaw, 32'h0);
    // Idle cycle: outputs and LFSR hold, OutValid drops.
    step(1'b0, 32'h12345678, 4'h3);
    checkVal("idle_valid", {31'd0, bus.OutValid}, 32'd0);
    checkVal("idle_sc",    bus.OutByteSc, 32'hC0C0C0C0);
    checkVal("idle_raw",   bus.OutByteRaw, 32'h0);
    step(1'b1, 32'h0, 4'h0);
    checkVal("idle_d4_sc", bus.OutByteSc, 32'h14141414);

    // Scrambling off, then back on: resumes at the third sequence position.
    bus.ScrambleEn = 1'b0;
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    checkVal("b_com_sc", bus.OutByteSc, 32'hBCBCBCBC);
    step(1'b1, 32'h0, 4'h0);
    checkVal("b_d1_sc", bus.OutByteSc, 32'h0);
    step(1'b1, 32'hA55A3C00, 4'h0);
    checkVal("b_d2_sc",  bus.OutByteSc, 32'hA55A3C00);
    checkVal("b_d2_raw", bus.OutByteRaw, 32'hA55A3C00);
    bus.ScrambleEn = 1'b1;
    step(1'b1, 32'h0, 4'h0);
    checkVal("b_d3_sc", bus.OutByteSc, 32'hC0C0C0C0);

    // SKP freezes the LFSR.
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    step(1'b1, 32'h0, 4'h0);
    checkVal("c_d1_sc", bus.OutByteSc, 32'hFFFFFFFF);
    step(1'b1, 32'h1C1C1C1C, 4'hF);
    checkVal("c_skp_sc", bus.OutByteSc, 32'h1C1C1C1C);
    step(1'b1, 32'h1C1C1C1C, 4'hF);
    step(1'b1, 32'h5A5A5A5A, 4'h0);
    checkVal("c_d2_sc",  bus.OutByteSc, 32'h4D4D4D4D);
    checkVal("c_d2_raw", bus.OutByteRaw, 32'h5A5A5A5A);

    // Other K symbols advance the LFSR and are not descrambled.
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    step(1'b1, 32'h0, 4'h0);
    step(1'b1, 32'hF7F7F7F7, 4'hF);
    checkVal("d_k_sc",   bus.OutByteSc, 32'hF7F7F7F7);
    checkVal("d_k_ctrl", {28'd0, bus.OutCtrl}, 32'hF);
    step(1'b1, 32'h0, 4'h0);
    checkVal("d_d3_sc", bus.OutByteSc, 32'hC0C0C0C0);

    // Lane independence: per-lane COM/SKP.
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    step(1'b1, 32'h0, 4'h0);
    checkVal("e_c2_sc", bus.OutByteSc, 32'hFFFFFFFF);
    step(1'b1, 32'h00BC0000, 4'b0100);
    checkVal("e_c3_sc",   bus.OutByteSc, 32'h17BC1717);
    checkVal("e_c3_ctrl", {28'd0, bus.OutCtrl}, 32'h4);
    step(1'b1, 32'h0000BC1C, 4'b0011);
    checkVal("e_c4_sc", bus.OutByteSc, 32'hC0FFBC1C);
    step(1'b1, 32'h0, 4'h0);
    checkVal("e_c5_sc", bus.OutByteSc, 32'h1417FFC0);

    // Asynchronous reset mid-stream with InValid held high.
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    step(1'b1, 32'h0, 4'h0);
    step(1'b1, 32'h0, 4'h0);
    step(1'b1, 32'h0, 4'h0);
    #2;
    Reset = 1'b1;
    #1;
    checkVal("f_rst_valid", {31'd0, bus.OutValid}, 32'd0);
    checkVal("f_rst_sc",    bus.OutByteSc, 32'd0);
    checkVal("f_rst_raw",   bus.OutByteRaw, 32'd0);
    @(posedge ClkPci);
    #1;
    Reset = 1'b0;
`ifdef RXDP_COMCOUNT_EN
    checkVal("f_comcnt0", {16'd0, bus.ComCount}, 32'd0);
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    step(1'b1, 32'hBCBCBCBC, 4'hF);
`endif
    step(1'b1, 32'hBCBCBCBC, 4'hF);
`ifdef RXDP_COMCOUNT_EN
    checkVal("f_comcnt12", {16'd0, bus.ComCount}, 32'd12);
`endif
    step(1'b1, 32'h0, 4'h0);
    checkVal("f_d1_sc", bus.OutByteSc, 32'hFFFFFFFF);

`ifdef RXDP_COMCOUNT_EN
    // Drive the counter up to FFFC, then across the saturation point.
    for (int i = 0; i < 16380; i++)
      step(1'b1, 32'hBCBCBCBC, 4'hF);
    checkVal("g_comcnt_fffc", {16'd0, bus.ComCount}, 32'h0000FFFC);
    step(1'b1, 32'h0000BCBC, 4'b0011);
    checkVal("g_comcnt_fffe", {16'd0, bus.ComCount}, 32'h0000FFFE);
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    checkVal("g_comcnt_sat", {16'd0, bus.ComCount}, 32'h0000FFFF);
    step(1'b1, 32'hBCBCBCBC, 4'hF);
    checkVal("g_comcnt_hold", {16'd0, bus.ComCount}, 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end
endmodule
